regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 3, number of write-back requesters.
REQ-002 Parameter: ADDR_W, default 5, register index width (32 registers).
REQ-003 Parameter: DATA_W, default 32, register data width.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port: clr_req  input  1  single-cycle pulse requesting a full register-file clear.
REQ-007 Port: req_valid  input  NUM_REQ  per-requester write request.
REQ-008 Port: req_addr  input  NUM_REQ*ADDR_W  destination index; requester i occupies slice i.
REQ-009 Port: req_data  input  NUM_REQ*DATA_W  write data; requester i occupies slice i.
REQ-010 Port: req_ready  output  NUM_REQ  one-hot-or-zero grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-011 Port: RegWrite  output  1  write strobe to the register file.
REQ-012 Port: Write_register  output  ADDR_W  write index to the register file.
REQ-013 Port: Write_data  output  DATA_W  write data to the register file.
REQ-014 Port: init_done  output  1  high only in RUN state.

Function
REQ-015 FSM states: INIT, RUN; reset enters INIT.
REQ-016 INIT: internal counter walks indices 1..31, one per cycle, driving RegWrite=1 and Write_data=0; after index 31 is issued, go to RUN next cycle (31 strobes in total).
REQ-017 INIT: req_ready SHALL be all zero; init_done=0.
REQ-018 RUN: combinational grant to at most one valid requester, chosen by round-robin starting at priority pointer ptr.
REQ-019 ptr resets to 0; after a grant to requester g, ptr becomes (g+1) mod NUM_REQ; with no grant, ptr holds.
REQ-020 Output registers: grant in cycle t produces RegWrite=1, Write_register=addr, Write_data=data in cycle t+1 (latency 1).
REQ-021 Request with addr 0 is granted and consumed, but produces RegWrite=0 the next cycle; x0 is never written.
REQ-022 No grant in cycle t -> RegWrite=0 in cycle t+1; Write_register and Write_data hold their previous values.
REQ-023 clr_req in RUN: no grant that cycle; an already-registered write still completes; next state INIT with counter=1.
REQ-024 clr_req during INIT: counter restarts at 1.
REQ-025 Requester payload must be stable while valid and not ready; the arbiter does not buffer ungranted requests.
REQ-026 Throughput: one write per cycle in RUN with continuous requests.

Reset
REQ-027 rst_n low asynchronously forces: state=INIT, counter=1, ptr=0, RegWrite=0, Write_register=0, Write_data=0, req_ready=0, init_done=0.
REQ-028 Reset mid-write or mid-INIT discards all progress; the full 31-cycle clear runs again after release.

Structure
REQ-029 Shared package holds: the FSM state encoding (INIT, RUN), the default ADDR_W/DATA_W, and the register count constant 32.
REQ-030 One sub-module: rr_arbiter (NUM_REQ-wide round-robin grant from valid and ptr, purely combinational); all other logic lives in the top.

Verification
REQ-031 Reset release -> RegWrite=1 for 31 consecutive cycles, Write_register 1..31, Write_data=0; then init_done=1; req_ready=0 throughout INIT.
REQ-032 RUN, all three requesters valid continuously (addr 5/6/7, data A/B/C) -> grants 0,1,2,0,...; writes (5,A),(6,B),(7,C) on consecutive cycles, each one cycle after its grant.
REQ-033 Requester 1 only valid, addr 0, data 0xDEADBEEF -> req_ready[1]=1, next cycle RegWrite=0.
REQ-034 clr_req pulse in the same cycle as req_valid=3'b001 -> req_ready=0; the previous registered write completes; a 31-cycle clear follows; the request is granted after init_done rises.
REQ-035 rst_n pulsed low at INIT counter=10 -> outputs zero immediately; after release, the clear restarts at index 1.
REQ-036 After a grant to requester 2, requesters 0 and 2 both valid -> requester 0 is granted (ptr wrapped to 0).

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int NUM_REGS   = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant
);

    logic w_found;

    // Scan priority slots k = 0..N-1; slot k maps to requester (ptr+k) mod N.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && i_valid[j] &&
                    (PW'((int'(i_ptr) + k) % NUM_REQ) == PW'(j))) begin
                    o_grant[j] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back port arbiter: clears x1..x31 after reset, then grants
// requesters round-robin into a single registered write port.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_req,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         Write_register,
    output logic [DATA_W-1:0]         Write_data,
    output logic                      init_done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
    logic [PW-1:0]       r_ptr, w_ptr_nxt;
    logic                r_we, w_we_nxt;
    logic [ADDR_W-1:0]   r_waddr, w_waddr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;

    logic                w_arb_en;
    logic [NUM_REQ-1:0]  w_valid;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ADDR_W-1:0]   w_gaddr;
    logic [DATA_W-1:0]   w_gdata;
    logic [PW-1:0]       w_gptr;

    assign w_arb_en = (r_state == RUN) && !clr_req;
    assign w_valid  = req_valid & {NUM_REQ{w_arb_en}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_arb (
        .i_valid (w_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_gaddr = '0;
        w_gdata = '0;
        w_gptr  = r_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gaddr = req_addr[i*ADDR_W +: ADDR_W];
                w_gdata = req_data[i*DATA_W +: DATA_W];
                w_gptr  = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        unique case (r_state)
            INIT: begin
                if (clr_req) begin
                    w_cnt_nxt = FIRST;
                end else begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = r_cnt;
                    w_wdata_nxt = '0;
                    if (r_cnt == LAST) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = FIRST;
                    end else begin
                        w_cnt_nxt = r_cnt + FIRST;
                    end
                end
            end
            RUN: begin
                if (clr_req) begin
                    w_state_nxt = INIT;
                    w_cnt_nxt   = FIRST;
                end else if (|w_grant) begin
                    w_ptr_nxt = w_gptr;
                    // x0 requests are consumed but never reach the file
                    if (w_gaddr != '0) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = w_gaddr;
                        w_wdata_nxt = w_gdata;
                    end
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_cnt   <= FIRST;
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_we    <= w_we_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign req_ready      = w_grant;
    assign RegWrite       = r_we;
    assign Write_register = r_waddr;
    assign Write_data     = r_wdata;
    assign init_done      = (r_state == RUN);

endmodule
